// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default sizing for the GCD engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/gcd_step.sv
// rtl/gcd_step.sv - one subtractive-Euclid step: operand compares and next operand values.
module gcd_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             xz,
  output logic             yz,
  output logic             eq,
  output logic             lt,
  output logic [WIDTH-1:0] x_next,
  output logic [WIDTH-1:0] y_next
);

  logic w_terminal;
  logic w_sub_x;
  logic w_sub_y;

  assign xz = (x == '0);
  assign yz = (y == '0);
  assign eq = (x == y);
  assign lt = (x < y);

  // The terminal guards shield both subtractions, so neither can wrap.
  assign w_terminal = xz | yz | eq;
  assign w_sub_y    = !w_terminal && lt;
  assign w_sub_x    = !w_terminal && !lt;

  assign x_next = w_sub_x ? (x - y) : x;
  assign y_next = w_sub_y ? (y - x) : y;

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - self-sequencing subtractive GCD with valid/ready operand and result ports.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic [CNT_W-1:0] iters,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_gcd;
  logic [CNT_W-1:0] r_iters;

  logic             w_xz;
  logic             w_yz;
  logic             w_eq;
  logic             w_lt;
  logic [WIDTH-1:0] w_x_next;
  logic [WIDTH-1:0] w_y_next;
  logic [CNT_W-1:0] w_iters_next;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .x      (r_x),
    .y      (r_y),
    .xz     (w_xz),
    .yz     (w_yz),
    .eq     (w_eq),
    .lt     (w_lt),
    .x_next (w_x_next),
    .y_next (w_y_next)
  );

  // Counter sticks at all-ones once reached.
  assign w_iters_next = (&r_iters) ? r_iters : (r_iters + CNT_W'(1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_gcd   <= '0;
      r_iters <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_x     <= xin;
            r_y     <= yin;
            r_iters <= '0;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (w_xz) begin
            r_gcd   <= r_y;
            r_state <= ST_DONE;
          end else if (w_yz || w_eq) begin
            r_gcd   <= r_x;
            r_state <= ST_DONE;
          end else begin
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_iters <= w_iters_next;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs depend on state only, never on the peer's valid/ready.
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign gcd       = r_gcd;
  assign iters     = r_iters;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed and randomised checks of gcd_engine at several widths.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;

  logic        a_iv, a_or;
  logic [31:0] a_x, a_y;
  logic        a_ir, a_ov, a_busy;
  logic [31:0] a_g, a_it;

  logic       b_iv, b_or;
  logic [7:0] b_x, b_y;
  logic       b8_ir, b8_ov, b8_busy;
  logic [7:0] b8_g, b8_it;
  logic       b4_ir, b4_ov, b4_busy;
  logic [7:0] b4_g;
  logic [3:0] b4_it;

  logic        c_iv, c_or;
  logic [15:0] c_x, c_y;
  logic        c_ir, c_ov, c_busy;
  logic [15:0] c_g, c_it;

  int vecs = 0;
  int errs = 0;

  gcd_engine #(.WIDTH(32), .CNT_W(32)) dut_a (
    .clk(clk), .clr(clr), .in_valid(a_iv), .in_ready(a_ir), .xin(a_x), .yin(a_y),
    .out_valid(a_ov), .out_ready(a_or), .gcd(a_g), .iters(a_it), .busy(a_busy));

  gcd_engine #(.WIDTH(8), .CNT_W(8)) dut_b8 (
    .clk(clk), .clr(clr), .in_valid(b_iv), .in_ready(b8_ir), .xin(b_x), .yin(b_y),
    .out_valid(b8_ov), .out_ready(b_or), .gcd(b8_g), .iters(b8_it), .busy(b8_busy));

  gcd_engine #(.WIDTH(8), .CNT_W(4)) dut_b4 (
    .clk(clk), .clr(clr), .in_valid(b_iv), .in_ready(b4_ir), .xin(b_x), .yin(b_y),
    .out_valid(b4_ov), .out_ready(b_or), .gcd(b4_g), .iters(b4_it), .busy(b4_busy));

  gcd_engine #(.WIDTH(16), .CNT_W(16)) dut_c (
    .clk(clk), .clr(clr), .in_valid(c_iv), .in_ready(c_ir), .xin(c_x), .yin(c_y),
    .out_valid(c_ov), .out_ready(c_or), .gcd(c_g), .iters(c_it), .busy(c_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Euclid by division; subtraction count is the sum of quotients, one fewer on exact division.
  function automatic void ref_gcd(input int unsigned a0, input int unsigned b0,
                                  output int unsigned g, output int unsigned n);
    int unsigned a, b, t, q, r;
    bit done;
    a = a0; b = b0; n = 0; g = 0; done = 0;
    if (a == 0) begin g = b; done = 1; end
    else if (b == 0) begin g = a; done = 1; end
    while (!done) begin
      if (a < b) begin t = a; a = b; b = t; end
      q = a / b;
      r = a % b;
      n += q;
      if (r == 0) begin g = b; n -= 1; done = 1; end
      else a = r;
    end
  endfunction

  task automatic a_wait(output int n);
    n = -1;
    for (int i = 1; i <= 4000; i++) begin
      tick();
      if (a_ov) begin n = i; break; end
    end
  endtask

  task automatic a_run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] eg, input int ei);
    int n;
    a_x = x; a_y = y; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    chk({tag, "_busy"}, a_busy, 1);
    chk({tag, "_inrdy_low"}, a_ir, 0);
    a_wait(n);
    chk({tag, "_lat"}, n, ei + 1);
    chk({tag, "_gcd"}, a_g, eg);
    chk({tag, "_iters"}, a_it, ei);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk({tag, "_ov_drop"}, a_ov, 0);
    chk({tag, "_inrdy"}, a_ir, 1);
  endtask

  initial begin
    int n;
    bit seen;
    int unsigned rx, ry, rg, rn;

    clr = 1'b1;
    a_iv = 0; a_or = 0; a_x = 0; a_y = 0;
    b_iv = 0; b_or = 0; b_x = 0; b_y = 0;
    c_iv = 0; c_or = 0; c_x = 0; c_y = 0;
    tick();
    tick();
    clr = 1'b0;

    chk("rst_inrdy", a_ir, 1);
    chk("rst_ov", a_ov, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_gcd", a_g, 0);
    chk("rst_iters", a_it, 0);

    a_run("t12_18", 12, 18, 6, 2);
    a_run("t0_7", 0, 7, 7, 0);
    a_run("t0_0", 0, 0, 0, 0);
    a_run("t9_9", 9, 9, 9, 0);
    a_run("t5_0", 5, 0, 5, 0);
    a_run("tmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    a_run("tmsb", 32'h8000_0000, 32'h4000_0000, 32'h4000_0000, 1);

    // backpressure with a competing operand pair held on the input
    a_x = 48; a_y = 36; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    a_wait(n);
    chk("bp_lat", n, 4);
    chk("bp_gcd", a_g, 12);
    chk("bp_iters", a_it, 3);
    a_x = 5; a_y = 10; a_iv = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_ov", a_ov, 1);
      chk("bp_hold_gcd", a_g, 12);
      chk("bp_hold_iters", a_it, 3);
      chk("bp_hold_inrdy", a_ir, 0);
    end
    a_or = 1'b1;
    tick();
    a_or = 1'b0;
    chk("bp_rel_inrdy", a_ir, 1);
    chk("bp_rel_busy", a_busy, 0);
    tick();
    a_iv = 1'b0;
    chk("bp_second_busy", a_busy, 1);
    a_wait(n);
    chk("bp_second_lat", n, 2);
    chk("bp_second_gcd", a_g, 5);
    chk("bp_second_iters", a_it, 1);
    a_or = 1'b1;
    tick();
    a_or = 1'b0;

    // reset during CALC discards the operation
    a_x = 1; a_y = 1000; a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    repeat (5) tick();
    chk("mid_busy", a_busy, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("mid_inrdy", a_ir, 1);
    chk("mid_busy_low", a_busy, 0);
    chk("mid_ov", a_ov, 0);
    chk("mid_gcd", a_g, 0);
    chk("mid_iters", a_it, 0);
    seen = 0;
    repeat (1100) begin
      tick();
      if (a_ov) seen = 1;
    end
    chk("mid_no_pulse", seen, 0);
    a_run("t21_14", 21, 14, 7, 2);

    // narrow datapath: long run and counter saturation
    b_x = 1; b_y = 255; b_iv = 1'b1;
    tick();
    b_iv = 1'b0;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (b8_ov) begin n = i; break; end
    end
    chk("w8_lat", n, 255);
    chk("w8_gcd", b8_g, 1);
    chk("w8_iters", b8_it, 254);
    chk("w8c4_ov", b4_ov, 1);
    chk("w8c4_gcd", b4_g, 1);
    chk("w8c4_iters_sat", b4_it, 15);
    b_or = 1'b1;
    tick();
    b_or = 1'b0;
    chk("w8_inrdy", b8_ir, 1);

    // randomised regression against the division-based model
    for (int k = 0; k < 300; k++) begin
      rx = (k % 17 == 3) ? 0 : $urandom_range(0, 1023);
      ry = (k % 23 == 5) ? 0 : $urandom_range(0, 1023);
      ref_gcd(rx, ry, rg, rn);
      c_x = rx[15:0]; c_y = ry[15:0]; c_iv = 1'b1;
      tick();
      c_iv = 1'b0;
      n = -1;
      for (int i = 1; i <= 2000; i++) begin
        tick();
        if (c_ov) begin n = i; break; end
      end
      chk("rnd_lat", n, rn + 1);
      chk("rnd_gcd", c_g, rg);
      chk("rnd_iters", c_it, rn);
      repeat ($urandom_range(0, 3)) tick();
      chk("rnd_stall_ov", c_ov, (n > 0) ? 1 : 0);
      c_or = 1'b1;
      tick();
      c_or = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
